clock_fault_generator: RTL and testbench



---
 rtl/clock_fault_generator.sv | 132 +++++++++++++
 tb/tb_clock_fault_generator.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/clock_fault_generator.sv
// rtl/clock_fault_generator.sv - divided test clock with commanded stop/glitch/stretch faults (optional FAULT_COUNT_EN)
module clock_fault_generator #(
    parameter int HALF_PERIOD = 5,
    parameter int LEN_W       = 8,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_type,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             gen_clk,
    output logic             fault_active,
    output logic             fault_done,
    output logic [CNT_W-1:0] edge_count
`ifdef FAULT_COUNT_EN
    ,
    output logic [7:0]       fault_count
`endif
);

    localparam int PH_W = $clog2(HALF_PERIOD);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(HALF_PERIOD - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STOP,
        ST_GLITCH,
        ST_STRETCH
    } state_t;

    state_t            state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic              odd_q, odd_d;
    logic              gen_d;
    logic              step;

    assign cmd_ready = (state_q == ST_RUN) && enable && !rst;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        rem_d   = rem_q;
        odd_d   = odd_q;
        gen_d   = gen_clk;
        step    = 1'b0;

        case (state_q)
            ST_RUN: begin
                step = enable;
                if (cmd_valid && cmd_ready && (cmd_type != 2'd0)) begin
                    rem_d = (cmd_len == '0) ? LEN_W'(1) : cmd_len;
                    odd_d = 1'b1;
                    case (cmd_type)
                        2'd1:    state_d = ST_STOP;
                        2'd2:    state_d = ST_GLITCH;
                        default: state_d = ST_STRETCH;
                    endcase
                end
            end
            ST_STOP: begin
                step = 1'b0;
            end
            ST_GLITCH: begin
                gen_d   = ~gen_clk;
                phase_d = '0;
            end
            ST_STRETCH: begin
                // Phase advances on the 1st, 3rd, ... fault cycle only.
                step  = odd_q;
                odd_d = ~odd_q;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (state_q != ST_RUN) begin
            rem_d = rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) begin
                state_d = ST_RUN;
            end
        end

        if (step) begin
            if (phase_q == PH_LAST) begin
                phase_d = '0;
                gen_d   = ~gen_clk;
            end else begin
                phase_d = phase_q + PH_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            phase_q      <= '0;
            rem_q        <= '0;
            odd_q        <= 1'b0;
            gen_clk      <= 1'b0;
            fault_active <= 1'b0;
            fault_done   <= 1'b0;
            edge_count   <= '0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            rem_q        <= rem_d;
            odd_q        <= odd_d;
            gen_clk      <= gen_d;
            fault_active <= (state_d != ST_RUN);
            fault_done   <= (state_q != ST_RUN) && (state_d == ST_RUN);
            if (gen_d && !gen_clk) begin
                edge_count <= edge_count + CNT_W'(1);
            end
        end
    end

`ifdef FAULT_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_count <= 8'd0;
        end else if ((state_q != ST_RUN) && (state_d == ST_RUN) && (fault_count != 8'hFF)) begin
            fault_count <= fault_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_clock_fault_generator.sv
// tb/tb_clock_fault_generator.sv - scoreboard bench for clock_fault_generator
module tb_clock_fault_generator;

    localparam int HP = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_type = 2'd0;
    logic [7:0]  cmd_len = 8'd0;
    logic        gen_clk;
    logic        fault_active;
    logic        fault_done;
    logic [15:0] edge_count;
`ifdef FAULT_COUNT_EN
    logic [7:0]  fault_count;
`endif

    clock_fault_generator #(.HALF_PERIOD(HP), .LEN_W(8), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_type     (cmd_type),
        .cmd_len      (cmd_len),
        .gen_clk      (gen_clk),
        .fault_active (fault_active),
        .fault_done   (fault_done),
        .edge_count   (edge_count)
`ifdef FAULT_COUNT_EN
        ,
        .fault_count  (fault_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        bit gen;
        int edges;
        bit fa;
        bit fd;
        bit cr;
        int fc;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: mode 0 = running, 1 = stopped, 2 = glitching, 3 = stretched.
    int m_mode  = 0;
    int m_phase = 0;
    int m_left  = 0;
    int m_cyc   = 0;
    bit m_gen   = 0;
    int m_edges = 0;
    bit m_fd    = 0;
    int m_fc    = 0;
    bit last_accept;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_advance();
        m_phase = m_phase + 1;
        if (m_phase == HP) begin
            m_phase = 0;
            m_gen   = !m_gen;
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit accept, input int t, input int l);
        bit old_gen;
        old_gen = m_gen;
        m_fd = 0;
        if (r) begin
            m_mode = 0; m_phase = 0; m_left = 0; m_gen = 0; m_edges = 0; m_fc = 0;
            return;
        end
        if (m_mode == 0) begin
            if (e) model_advance();
            if (accept && t != 0) begin
                m_mode = t;
                m_left = (l == 0) ? 1 : l;
                m_cyc  = 0;
            end
        end else begin
            m_cyc++;
            if (m_mode == 2) begin
                m_gen   = !m_gen;
                m_phase = 0;
            end else if (m_mode == 3 && (m_cyc % 2) == 1) begin
                model_advance();
            end
            m_left--;
            if (m_left == 0) begin
                m_mode = 0;
                m_fd   = 1;
                if (m_fc < 255) m_fc++;
            end
        end
        if (!old_gen && m_gen) m_edges = (m_edges + 1) % 65536;
    endtask

    task automatic cyc(input bit r, input bit e, input bit v, input int t, input int l);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; enable = e; cmd_valid = v; cmd_type = t[1:0]; cmd_len = l[7:0];
        x.gen = m_gen; x.edges = m_edges; x.fa = (m_mode != 0); x.fd = m_fd; x.fc = m_fc;
        x.cr  = !r && (m_mode == 0) && e;
        sb.push_back(x);
        last_accept = x.cr && v;
        model_step(r, e, last_accept, t, l % 256);
    endtask

    task automatic issue(input int t, input int l);
        int n;
        n = 0;
        last_accept = 0;
        while (!last_accept && n < 300) begin
            cyc(0, 1, 1, t, l);
            n++;
        end
        if (!last_accept) begin
            errors++;
            $display("FAIL accept_timeout: got 0 expected 1");
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            chk("gen_clk", 32'(gen_clk), 32'(x.gen));
            chk("edge_count", 32'(edge_count), 32'(x.edges));
            chk("fault_active", 32'(fault_active), 32'(x.fa));
            chk("fault_done", 32'(fault_done), 32'(x.fd));
            chk("cmd_ready", 32'(cmd_ready), 32'(x.cr));
`ifdef FAULT_COUNT_EN
            chk("fault_count", 32'(fault_count), 32'(x.fc));
`endif
        end
    end

    initial begin
        int k;
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 100; i++) cyc(0, 1, 0, 0, 0);
        @(negedge clk);
        chk("idle_edges_100", 32'(edge_count), 32'd10);

        k = 0;
        while (!m_gen && k < 20) begin cyc(0, 1, 0, 0, 0); k++; end
        issue(1, 40);
        for (int i = 0; i < 45; i++) cyc(0, 1, 0, 0, 0);
        k = 0;
        while (m_gen && k < 20) begin cyc(0, 1, 0, 0, 0); k++; end
        issue(2, 6);
        for (int i = 0; i < 12; i++) cyc(0, 1, 0, 0, 0);
        issue(3, 20);
        for (int i = 0; i < 25; i++) cyc(0, 1, 0, 0, 0);
        issue(1, 10);
        issue(2, 4);
        for (int i = 0; i < 8; i++) cyc(0, 1, 0, 0, 0);
        issue(0, 9);
        issue(1, 50);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        issue(2, 3);
        issue(1, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, 0, 0);

        for (int i = 0; i < 250; i++) begin
            int pick;
            pick = $urandom_range(0, 99);
            if (pick < 3) begin
                cyc(1, $urandom_range(0, 1), 0, 0, 0);
            end else if (pick < 55) begin
                int n;
                n = $urandom_range(1, 12);
                for (int j = 0; j < n; j++) cyc(0, ($urandom_range(0, 4) != 0), 0, 0, 0);
            end else begin
                issue($urandom_range(0, 3), $urandom_range(0, 25));
                if ($urandom_range(0, 3) == 0) cyc(0, 0, 0, 0, 0);
            end
        end
        cyc(0, 1, 0, 0, 0);

        k = 0;
        while (sb.size() > 0 && k < 10) begin @(posedge clk); k++; end
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL drain: got %0d expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
